// File: rtl/sample_pkg.sv
// Shared types and constants for the sample board LED path.
// The polarity constants are shared with the board input wrapper.
package sample_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_FADE  = 2'd2
    } state_t;

    localparam int DEFAULT_PWM_BITS = 8;

    // Board LEDs sink current: driving the pin low lights the LED.
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/sample_pwm_channel.sv
// One PWM colour channel: duty register plus registered comparator output.
// led_n lags pwm_cnt by one cycle; duty only moves on a wrap cycle, so no period sees a partial duty.
module sample_pwm_channel
    import sample_pkg::*;
#(
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wrap,
    input  logic                load,
    input  logic [PWM_BITS-1:0] load_duty,
    input  logic                step_up,
    input  logic                step_dn,
    output logic [PWM_BITS-1:0] duty,
    output logic                led_n
);

    always_ff @(posedge clock) begin
        if (reset) begin
            duty  <= '0;
            led_n <= LED_OFF;
        end else begin
            led_n <= (pwm_cnt < duty) ? LED_ON : LED_OFF;
            if (wrap) begin
                if (load) begin
                    duty <= load_duty;
                end else if (step_up) begin
                    duty <= duty + 1'b1;
                end else if (step_dn) begin
                    duty <= duty - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sample_led_driver.sv
// RGB LED driver: accepts colour commands and renders them as glitch-free PWM, immediately or as a linear fade.
// One command in flight; cmd_ready is low while a command is being applied or faded (up to a full PWM period per apply).
module sample_led_driver
    import sample_pkg::*;
#(
    parameter int PWM_BITS     = DEFAULT_PWM_BITS,
    parameter int FADE_PERIODS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PWM_BITS-1:0] cmd_red,
    input  logic [PWM_BITS-1:0] cmd_green,
    input  logic [PWM_BITS-1:0] cmd_blue,
    input  logic                cmd_fade,
    output logic                busy,
    output logic                led_red_n,
    output logic                led_green_n,
    output logic                led_blue_n
);

    localparam int                PS_W    = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(FADE_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    state_t              state;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] target    [3];
    logic [PWM_BITS-1:0] duty      [3];
    logic [PWM_BITS-1:0] next_duty [3];
    logic [PWM_BITS-1:0] cmd_duty  [3];
    logic [2:0]          step_up;
    logic [2:0]          step_dn;
    logic [2:0]          led_n;
    logic                wrap;
    logic                xfer;
    logic                fade_step;
    logic                load;
    logic                all_done;

    assign cmd_duty[0] = cmd_red;
    assign cmd_duty[1] = cmd_green;
    assign cmd_duty[2] = cmd_blue;

    assign wrap      = (pwm_cnt == PWM_MAX);
    assign cmd_ready = (state == ST_IDLE) && !reset;
    assign busy      = (state != ST_IDLE);
    assign xfer      = cmd_valid && cmd_ready;
    assign load      = (state == ST_APPLY);
    assign fade_step = wrap && (state == ST_FADE) && (presc == PS_LAST);

    // Completion is judged on the post-step duty so the fade ends on the same wrap as its last step.
    always_comb begin
        all_done = 1'b1;
        step_up  = '0;
        step_dn  = '0;
        for (int i = 0; i < 3; i++) begin
            next_duty[i] = duty[i];
            step_up[i]   = fade_step && (duty[i] < target[i]);
            step_dn[i]   = fade_step && (duty[i] > target[i]);
            if (step_up[i]) begin
                next_duty[i] = duty[i] + 1'b1;
            end else if (step_dn[i]) begin
                next_duty[i] = duty[i] - 1'b1;
            end
            if (next_duty[i] != target[i]) begin
                all_done = 1'b0;
            end
        end
    end

    // The fade flag is carried by the state itself: APPLY versus FADE.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt <= '0;
            presc   <= '0;
            state   <= ST_IDLE;
            for (int i = 0; i < 3; i++) begin
                target[i] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        for (int i = 0; i < 3; i++) begin
                            target[i] <= cmd_duty[i];
                        end
                        presc <= '0;
                        state <= cmd_fade ? ST_FADE : ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (wrap) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FADE: begin
                    if (wrap) begin
                        presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
                        if (all_done) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        sample_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .pwm_cnt   (pwm_cnt),
            .wrap      (wrap),
            .load      (load),
            .load_duty (target[i]),
            .step_up   (step_up[i]),
            .step_dn   (step_dn[i]),
            .duty      (duty[i]),
            .led_n     (led_n[i])
        );
    end

    assign led_red_n   = led_n[0];
    assign led_green_n = led_n[1];
    assign led_blue_n  = led_n[2];

endmodule

// File: doc/sample_led_driver.md
Name: sample_led_driver

Overview:
- Output-side counterpart to the board input conditioning. Drives the board's three active-low RGB LED pins.
- Accepts 8-bit colour commands over a valid/ready handshake and renders them as glitch-free PWM.
- Each command either applies immediately or fades linearly from the current colour.
- Sits between sample application logic (e.g. a `*_main` block) and the LED pins at top level.

Parameters:
PWM_BITS, 8, width of PWM counter and duty values; PWM period = 2^PWM_BITS clocks
FADE_PERIODS, 4, PWM periods per fade step (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_red  input  PWM_BITS  target red duty
cmd_green  input  PWM_BITS  target green duty
cmd_blue  input  PWM_BITS  target blue duty
cmd_fade  input  1  1 = linear fade to target, 0 = immediate
busy  output  1  command in progress (not IDLE)
led_red_n  output  1  red LED, active-low
led_green_n  output  1  green LED, active-low
led_blue_n  output  1  blue LED, active-low

Behaviour:
- Reset (synchronous, active-high):
  - pwm_cnt=0, duty_*=0, target_*=0, fade prescaler=0, state=IDLE.
  - led_*_n=1 (all off), cmd_ready=0, busy=0.
  - cmd_ready=1 from the first cycle after reset deassertion.
- PWM counter: free-running 0..2^PWM_BITS-1, wraps to 0. "wrap" = cycle where pwm_cnt == max.
- LED outputs are registered: led_x_n <= ~(pwm_cnt < duty_x), i.e. one cycle of latency.
  - duty=0 gives always off.
  - duty=max gives on for max of 2^PWM_BITS clocks (never 100%).
- duty_* changes only on a wrap cycle, so no PWM period ever sees a partial duty.
- Handshake:
  - Transfer occurs when cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE) && !reset. It is combinational from state.
  - cmd_* and cmd_fade are captured into target_* and a fade flag on the transfer cycle.
  - cmd_* is ignored at all other times.
- FSM states: IDLE, APPLY, FADE.
  - IDLE: on transfer, go to APPLY if fade=0, or to FADE if fade=1.
  - APPLY: on the next wrap, duty_* <= target_*, then IDLE.
  - FADE: the prescaler counts wraps.
    - Each FADE_PERIODS-th wrap, every channel whose duty != target moves by exactly 1 toward target. Increment and decrement are both allowed and are independent per channel.
    - When all duty == target (checked after the update), go to IDLE on that same wrap.
    - The prescaler clears on FADE entry.
    - If target == duty at entry, return to IDLE on the first wrap.
- busy = (state != IDLE).
- No arithmetic overflow: steps only move toward the target, so duty stays in range.
- Reset mid-fade: LEDs go off next cycle and all state clears. PWM restarts at 0.
- cmd_valid held high during busy: no transfer. The command is accepted on the first IDLE cycle.
- A command arriving on a wrap cycle while IDLE is captured that cycle. APPLY then waits for the following wrap (up to one full period of latency).

Decomposition:
- Shared package `sample_pkg`:
  - FSM state enum (IDLE/APPLY/FADE).
  - Localparam for the default PWM_BITS.
  - LED active-low polarity constant, reused by the input wrapper.
- One natural sub-module, `sample_pwm_channel`:
  - Holds duty register and comparator/output flop.
  - Inputs: wrap, load, step_up, step_dn.
  - Instantiated three times. FSM, counter and prescaler stay in the parent.

Test Plan:
- Reset release:
  - All led_*_n = 1, busy = 0, cmd_ready = 1 one cycle after reset falls.
  - LEDs stay off for 3 full periods.
- Immediate command R=64 G=0 B=255, fade=0:
  - After the next wrap, per 256-clock period led_red_n is low for exactly 64 clocks, led_green_n never low, led_blue_n low for 255 clocks.
  - busy drops at that wrap.
- Fade from R=0 to R=3, FADE_PERIODS=4:
  - Red duty becomes 1, 2, 3 at wraps 4, 8, 12 after acceptance.
  - busy deasserts at wrap 12.
  - cmd_ready stays 0 throughout.
- Mixed-direction fade from R=10 B=0 to R=8 B=2:
  - Red decrements and blue increments on the same step wraps.
  - Done after 2 steps.
- Backpressure: cmd_valid held high with a new colour during a fade.
  - Exactly one transfer, on the first IDLE cycle.
  - The new target is applied afterward.
- Reset asserted mid-fade (duty R=5):
  - Next cycle all LEDs are off and state is IDLE.
  - After release, an immediate command R=1 produces a 1-clock low pulse per period.
